// File: rtl/dtw_axil_master.sv
// Command-driven AXI4-lite master: single write, single read, or masked poll-until-match.
// Optional per-command watchdog enabled by defining DTW_AXIL_TIMEOUT_EN.
module dtw_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              aclk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_mask,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                              rsp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [DW-1:0]   mask_reg, mask_next;
  logic [DW-1:0]   rdata_reg, rdata_next;
  logic            poll_reg, poll_next;
  logic            aw_done_reg, aw_done_next;
  logic            w_done_reg, w_done_next;
  logic            err_reg, err_next;
  logic [1:0]      gap_reg, gap_next;

`ifdef DTW_AXIL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0]   timer_reg, timer_next;
`endif

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      mask_reg    <= '0;
      rdata_reg   <= '0;
      poll_reg    <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      err_reg     <= 1'b0;
      gap_reg     <= '0;
`ifdef DTW_AXIL_TIMEOUT_EN
      timer_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      mask_reg    <= mask_next;
      rdata_reg   <= rdata_next;
      poll_reg    <= poll_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      err_reg     <= err_next;
      gap_reg     <= gap_next;
`ifdef DTW_AXIL_TIMEOUT_EN
      timer_reg   <= timer_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    mask_next    = mask_reg;
    rdata_next   = rdata_reg;
    poll_next    = poll_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    err_next     = err_reg;
    gap_next     = gap_reg;
`ifdef DTW_AXIL_TIMEOUT_EN
    timer_next   = timer_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next    = cmd_addr;
          wdata_next   = cmd_wdata;
          mask_next    = cmd_mask;
          poll_next    = (cmd_op == 2'd2);
          rdata_next   = '0;
          err_next     = 1'b0;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          gap_next     = '0;
          state_next   = (cmd_op == 2'd0) ? WR : RD_AR;
        end
      end
      WR: begin
        // AW and W retire independently; each valid is masked once its own handshake is done.
        aw_done_next = aw_done_reg | m_axi_awready;
        w_done_next  = w_done_reg | m_axi_wready;
        if (aw_done_next && w_done_next) state_next = WR_B;
      end
      WR_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_next = 1'b1;
          state_next = RSP;
        end
      end
      RD_AR: begin
        if (m_axi_arready) state_next = RD_R;
      end
      RD_R: begin
        if (gap_reg != 2'd0) begin
          gap_next = gap_reg - 2'd1;
          if (gap_reg == 2'd1) state_next = RD_AR;
        end else if (m_axi_rvalid) begin
          rdata_next = m_axi_rdata;
          if (m_axi_rresp != 2'b00) begin
            err_next   = 1'b1;
            state_next = RSP;
          end else if (!poll_reg || ((m_axi_rdata & mask_reg) == (wdata_reg & mask_reg))) begin
            state_next = RSP;
          end else begin
            gap_next = 2'd2;
          end
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef DTW_AXIL_TIMEOUT_EN
    // The acceptance cycle counts as cycle 1, so expiry lands TIMEOUT_CYCLES after acceptance.
    if (state_reg == IDLE) begin
      if (cmd_valid) timer_next = TW'(1);
    end else if (state_reg != RSP) begin
      timer_next = timer_reg + TW'(1);
      if (timer_next >= TIMER_LIMIT) begin
        err_next   = 1'b1;
        state_next = RSP;
      end
    end
`endif
  end

  // All handshake outputs decode registered state only, never the ready inputs.
  assign cmd_ready     = (state_reg == IDLE);
  assign rsp_valid     = (state_reg == RSP);
  assign rsp_rdata     = rdata_reg;
  assign rsp_err       = err_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_reg == WR) && !aw_done_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_reg == WR) && !w_done_reg;
  assign m_axi_bready  = (state_reg == WR_B);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_reg == RD_AR);
  assign m_axi_rready  = (state_reg == RD_R) && (gap_reg == 2'd0);

endmodule
